// File: rtl/config_readback_pkg.sv
// rtl/config_readback_pkg.sv - shared types, constants and CRC helper for config_readback
package config_readback_pkg;

    localparam int         BYTE_W   = 8;
    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAD  = 2'd1,
        TAIL = 2'd2
    } state_e;

    // CRC-8, MSB-first, one whole byte per call
    function automatic logic [BYTE_W-1:0] crc8_update(input logic [BYTE_W-1:0] crc,
                                                      input logic [BYTE_W-1:0] data);
        logic [BYTE_W-1:0] c;
        c = crc ^ data;
        for (int i = 0; i < BYTE_W; i++) begin
            c = c[BYTE_W-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/readback_fifo.sv
// rtl/readback_fifo.sv - single-clock byte FIFO with push/pop/full/empty
module readback_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO is still accepted when the head leaves on the same edge
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is forced to zero when empty so the output never shows stale entries
    assign pop_data_o = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

    // Pointer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + ONE;
    end

    // Pointer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, no reset needed since pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/config_readback.sv
// rtl/config_readback.sv - config chain bit packer, flush FSM and UART byte queue (optional CRC tail: READBACK_CRC_EN)
module config_readback
    import config_readback_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic              SCLK,
    input  logic              RESET,
    input  logic              SHIFT_ENABLE,
    input  logic              SHIFT_TAIL,
    input  logic              FLUSH,
    input  logic              CLEAR,
    input  logic              UART_READY,
    output logic              TX_VALID,
    output logic [BYTE_W-1:0] TX_DATA,
    output logic              BUSY,
    output logic              OVERFLOW
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [BYTE_W-1:0] pend_byte_q, pend_byte_d;
    logic              ovf_q, ovf_d;

    logic              fifo_full, fifo_empty;
    logic [BYTE_W-1:0] fifo_rdata;
    logic              pop, push, push_ok, push_req;
    logic [BYTE_W-1:0] push_data;
    logic              capture;
    logic              pad_req, tail_req;

`ifdef READBACK_CRC_EN
    logic [BYTE_W-1:0] crc_q, crc_d;
`endif

    readback_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk_i       (SCLK),
        .rst_i       (RESET),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign TX_VALID = !fifo_empty;
    assign TX_DATA  = fifo_rdata;
    assign OVERFLOW = ovf_q;
    assign pop      = TX_VALID && UART_READY;
    assign push_ok  = !fifo_full || pop;
    assign capture  = SHIFT_ENABLE && !BUSY;

    // FSM outputs: busy flag and which flush stage wants a push this cycle
    always_comb begin
        BUSY     = (state_q != IDLE);
        pad_req  = (state_q == PAD) && (cnt_q != 3'd0);
        tail_req = 1'b0;
`ifdef READBACK_CRC_EN
        tail_req = (state_q == TAIL);
`endif
    end

    // FSM next state; PAD and TAIL wait for FIFO room rather than drop their byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (FLUSH) state_d = PAD;
            PAD:     if (!pad_req || push_ok) state_d = TAIL;
            TAIL:    if (!tail_req || push_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Push source mux; completed bytes only exist in IDLE/PAD, so sources never overlap
    always_comb begin
        push_req  = pend_q || pad_req || tail_req;
        push_data = pend_q ? pend_byte_q : shreg_q;
`ifdef READBACK_CRC_EN
        if (tail_req) push_data = crc_q;
`endif
        push = push_req && push_ok;
    end

    // Bit packer: LSB-first, completed byte is staged one cycle before its push
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        pend_d      = 1'b0;
        pend_byte_d = pend_byte_q;
        if (capture) begin
            if (cnt_q == 3'd7) begin
                pend_d      = 1'b1;
                pend_byte_d = {SHIFT_TAIL, shreg_q[6:0]};
                shreg_d     = '0;
                cnt_d       = 3'd0;
            end else begin
                shreg_d[cnt_q] = SHIFT_TAIL;
                cnt_d          = cnt_q + 3'd1;
            end
        end else if (pad_req && push_ok) begin
            // unused upper bits are already zero because the register clears on each byte
            shreg_d = '0;
            cnt_d   = 3'd0;
        end
    end

    // Sticky overflow; a new loss event beats a simultaneous clear
    always_comb begin
        ovf_d = ovf_q;
        if (CLEAR) ovf_d = 1'b0;
        if ((SHIFT_ENABLE && BUSY) || (pend_q && !push_ok)) ovf_d = 1'b1;
    end

`ifdef READBACK_CRC_EN
    // CRC accumulates over every data byte that enters the FIFO and restarts after the tail
    always_comb begin
        crc_d = crc_q;
        if (push && tail_req)
            crc_d = '0;
        else if (push)
            crc_d = crc8_update(crc_q, push_data);
    end
`endif

    // State registers
    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= 3'd0;
            pend_q      <= 1'b0;
            pend_byte_q <= '0;
            ovf_q       <= 1'b0;
`ifdef READBACK_CRC_EN
            crc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
            ovf_q       <= ovf_d;
`ifdef READBACK_CRC_EN
            crc_q       <= crc_d;
`endif
        end
    end

endmodule
